// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port RAM between the CPU memory
// interface and the front-panel loader/checker. One RAM cycle per grant,
// read data returned with a one-cycle valid pulse to the winner.
//
// Optional feature macro: RAM_ARB_AGING_EN
//   defined   -> run-mode aging counter forces a panel grant after MAX_WAIT
//                denied arbitration cycles
//   undefined -> strict CPU priority in run mode (panel may starve)
//
// Handshake: a requester raises req with we/addr/wdata and holds them stable
// until it sees a one-cycle gnt; the request is latched at grant, so req still
// high in the cycle after gnt is a new request. For reads, rvalid pulses one
// cycle after gnt with rdata valid in that same cycle; rdata then holds until
// the next read for that requester completes.
module ram_port_arbiter #(
    parameter int AW       = 16,
    parameter int DW       = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [1:0]    cpustate_i,
    input  logic          cpu_req_i,
    input  logic          cpu_we_i,
    input  logic [AW-1:0] cpu_addr_i,
    input  logic [DW-1:0] cpu_wdata_i,
    output logic          cpu_gnt_o,
    output logic          cpu_rvalid_o,
    output logic [DW-1:0] cpu_rdata_o,
    input  logic          pnl_req_i,
    input  logic          pnl_we_i,
    input  logic [AW-1:0] pnl_addr_i,
    input  logic [DW-1:0] pnl_wdata_i,
    output logic          pnl_gnt_o,
    output logic          pnl_rvalid_o,
    output logic [DW-1:0] pnl_rdata_o,
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    output logic          busy_o,
    output logic [1:0]    state_o,
    output logic [2:0]    age_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [2:0] AGE_MAX = 3'(MAX_WAIT);

    state_t        state_q, state_d;
    logic          owner_q, owner_d;   // 1 = panel owns the access in flight
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] pnl_rdata_q, pnl_rdata_d;

    logic run_mode;
    logic age_force;
    logic pnl_wins;
    logic cpu_wins;

    assign run_mode = (cpustate_i == 2'b10) || (cpustate_i == 2'b11);

`ifdef RAM_ARB_AGING_EN
    logic [2:0] age_q, age_d;

    assign age_force = (age_q >= AGE_MAX);
    assign age_o     = age_q;

    // Aging next-state: count denied panel arbitrations in run mode, saturate,
    // clear on a panel grant or whenever the CPU is in panel mode.
    always_comb begin
        age_d = age_q;
        if (!run_mode || (state_q == S_ACC && owner_q)) begin
            age_d = 3'd0;
        end else if (state_q == S_IDLE && pnl_req_i && cpu_wins && age_q < AGE_MAX) begin
            age_d = age_q + 3'd1;
        end
    end

    // Aging counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            age_q <= 3'd0;
        end else begin
            age_q <= age_d;
        end
    end
`else
    assign age_force = 1'b0;
    assign age_o     = 3'd0;
`endif

    // Winner selection, only acted upon in IDLE.
    assign pnl_wins = pnl_req_i && (!run_mode || !cpu_req_i || age_force);
    assign cpu_wins = cpu_req_i && !pnl_wins;

    // State, latched request and read-data registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            pnl_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            pnl_rdata_q <= pnl_rdata_d;
        end
    end

    // FSM next-state and outputs.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cpu_rdata_d  = cpu_rdata_q;
        pnl_rdata_d  = pnl_rdata_q;
        cpu_gnt_o    = 1'b0;
        pnl_gnt_o    = 1'b0;
        cpu_rvalid_o = 1'b0;
        pnl_rvalid_o = 1'b0;
        mem_en_o     = 1'b0;
        mem_we_o     = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        cpu_rdata_o  = cpu_rdata_q;
        pnl_rdata_o  = pnl_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (pnl_wins) begin
                    owner_d = 1'b1;
                    we_d    = pnl_we_i;
                    addr_d  = pnl_addr_i;
                    wdata_d = pnl_wdata_i;
                    state_d = S_ACC;
                end else if (cpu_wins) begin
                    owner_d = 1'b0;
                    we_d    = cpu_we_i;
                    addr_d  = cpu_addr_i;
                    wdata_d = cpu_wdata_i;
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                mem_en_o    = 1'b1;
                mem_we_o    = we_q;
                mem_addr_o  = addr_q;
                mem_wdata_o = wdata_q;
                cpu_gnt_o   = !owner_q;
                pnl_gnt_o   = owner_q;
                state_d     = we_q ? S_IDLE : S_RESP;
            end
            S_RESP: begin
                // RAM data is valid this cycle; forward it and keep a copy.
                if (owner_q) begin
                    pnl_rvalid_o = 1'b1;
                    pnl_rdata_o  = mem_rdata_i;
                    pnl_rdata_d  = mem_rdata_i;
                end else begin
                    cpu_rvalid_o = 1'b1;
                    cpu_rdata_o  = mem_rdata_i;
                    cpu_rdata_d  = mem_rdata_i;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy_o  = (state_q != S_IDLE);
    assign state_o = state_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a small behavioural RAM.
module tb_ram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  cpustate;
    logic        cpu_req, cpu_we, pnl_req, pnl_we;
    logic [15:0] cpu_addr, pnl_addr;
    logic [7:0]  cpu_wdata, pnl_wdata;
    logic        cpu_gnt, cpu_rvalid, pnl_gnt, pnl_rvalid;
    logic [7:0]  cpu_rdata, pnl_rdata;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic        busy;
    logic [1:0]  state;
    logic [2:0]  age;

    logic [7:0]  ram [0:255];

    int errors = 0;
    int checks = 0;

    ram_port_arbiter #(.AW(16), .DW(8), .MAX_WAIT(4)) dut (
        .clk_i(clk), .rst_i(rst), .cpustate_i(cpustate),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
        .cpu_wdata_i(cpu_wdata), .cpu_gnt_o(cpu_gnt), .cpu_rvalid_o(cpu_rvalid),
        .cpu_rdata_o(cpu_rdata),
        .pnl_req_i(pnl_req), .pnl_we_i(pnl_we), .pnl_addr_i(pnl_addr),
        .pnl_wdata_i(pnl_wdata), .pnl_gnt_o(pnl_gnt), .pnl_rvalid_o(pnl_rvalid),
        .pnl_rdata_o(pnl_rdata),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
        .busy_o(busy), .state_o(state), .age_o(age)
    );

    // Clock
    always #5 clk = ~clk;

    // RAM model: synchronous write, registered read; preloaded under reset.
    always @(posedge clk) begin
        if (rst) begin
            ram[8'h12] <= 8'hA5;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr[7:0]];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int cpu_g, pnl_g, both, seen;
        rst = 1'b1; cpustate = 2'b00;
        cpu_req = 0; cpu_we = 0; cpu_addr = 16'h0; cpu_wdata = 8'h0;
        pnl_req = 0; pnl_we = 0; pnl_addr = 16'h0; pnl_wdata = 8'h0;

        // Reset
        repeat (3) step();
        check("rst_busy", busy, 0);
        check("rst_state", state, 0);
        check("rst_gnt", {cpu_gnt, pnl_gnt, cpu_rvalid, pnl_rvalid}, 0);
        check("rst_mem", {mem_en, mem_we, mem_addr, mem_wdata}, 0);
        check("rst_rdata", {cpu_rdata, pnl_rdata}, 0);
        check("rst_age", age, 0);
        rst = 1'b0;
        step();
        check("post_rst_busy", busy, 0);

        // CPU read in run mode
        cpustate = 2'b10; cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0012;
        step();
        check("rd_cpu_gnt", cpu_gnt, 1);
        check("rd_pnl_gnt", pnl_gnt, 0);
        check("rd_mem", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 16'h0012});
        cpu_req = 0;
        step();
        check("rd_rvalid", cpu_rvalid, 1);
        check("rd_rdata", cpu_rdata, 8'hA5);
        check("rd_mem_en_resp", mem_en, 0);
        step();
        check("rd_busy_c3", busy, 0);
        check("rd_rvalid_c3", cpu_rvalid, 0);
        check("rd_rdata_hold", cpu_rdata, 8'hA5);

        // Panel write in panel mode with concurrent CPU write
        cpustate = 2'b00;
        pnl_req = 1; pnl_we = 1; pnl_addr = 16'h0003; pnl_wdata = 8'h3C;
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0020; cpu_wdata = 8'h77;
        step();
        check("pw_pnl_gnt", pnl_gnt, 1);
        check("pw_cpu_gnt", cpu_gnt, 0);
        check("pw_mem", {mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 16'h0003, 8'h3C});
        pnl_req = 0;
        step();
        check("pw_idle", busy, 0);
        check("pw_ram3", ram[3], 8'h3C);
        step();
        check("pw_cpu_next", cpu_gnt, 1);
        check("pw_cpu_addr", mem_addr, 16'h0020);
        cpu_req = 0;
        step();
        check("pw_ram20", ram[8'h20], 8'h77);

        // Run-mode contention: CPU writes back-to-back, panel reads continuously
        cpustate = 2'b10;
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0040; cpu_wdata = 8'h11;
        pnl_req = 1; pnl_we = 0; pnl_addr = 16'h0012;
`ifdef RAM_ARB_AGING_EN
        cpu_g = 0; both = 0; seen = 0;
        for (int i = 0; i < 40 && seen == 0; i++) begin
            step();
            if (cpu_gnt && pnl_gnt) both++;
            if (cpu_gnt) cpu_g++;
            if (pnl_gnt) seen = 1;
        end
        check("age_pnl_seen", seen, 1);
        check("age_cpu_grants", cpu_g, 4);
        check("age_exclusive", both, 0);
        pnl_req = 0;
        step();
        check("age_pnl_rvalid", pnl_rvalid, 1);
        check("age_pnl_rdata", pnl_rdata, 8'hA5);
        check("age_cleared", age, 0);
        cpu_req = 0;
        step();
        step();
`else
        cpu_g = 0; pnl_g = 0; both = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (cpu_gnt && pnl_gnt) both++;
            if (cpu_gnt) cpu_g++;
            if (pnl_gnt) pnl_g++;
        end
        check("strict_no_pnl", pnl_g, 0);
        check("strict_cpu_grants", cpu_g, 50);
        check("strict_exclusive", both, 0);
        check("strict_age", age, 0);
        pnl_req = 0; cpu_req = 0;
        step();
        step();
`endif
        check("cont_idle", busy, 0);

        // cpustate toggles during CPU ACC
        cpustate = 2'b10;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0012;
        pnl_req = 1; pnl_we = 1; pnl_addr = 16'h0005; pnl_wdata = 8'h5A;
        step();
        check("tog_cpu_gnt", cpu_gnt, 1);
        check("tog_pnl_gnt0", pnl_gnt, 0);
        cpustate = 2'b00;
        step();
        check("tog_cpu_rvalid", cpu_rvalid, 1);
        check("tog_cpu_rdata", cpu_rdata, 8'hA5);
        step();
        step();
        check("tog_pnl_gnt", pnl_gnt, 1);
        check("tog_cpu_gnt0", cpu_gnt, 0);
        check("tog_pnl_addr", mem_addr, 16'h0005);
        pnl_req = 0;
        step();
        check("tog_ram5", ram[5], 8'h5A);
        step();
        check("tog_cpu_gnt2", cpu_gnt, 1);
        cpu_req = 0;
        step();
        step();

        // Reset asserted in RESP of a CPU read
        cpustate = 2'b10;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0012;
        step();
        check("mr_gnt", cpu_gnt, 1);
        cpu_req = 0;
        step();
        rst = 1'b1;
        #1;
        check("mr_no_rvalid", cpu_rvalid, 0);
        check("mr_state", state, 0);
        check("mr_busy", busy, 0);
        check("mr_rdata_clr", cpu_rdata, 0);
        step();
        check("mr_no_rvalid2", cpu_rvalid, 0);
        rst = 1'b0;
        step();
        check("mr_idle", state, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
